// File: rtl/cell_scan_ctrl.sv
// cell_scan_ctrl: 16x4-bit cell bank with valid/ready writes, prescaled scan index, sequential clear; optional CELL_LOCK_EN adds wr_err and write-locking
module cell_scan_ctrl #(
    parameter int         SCAN_DIV  = 4,
    parameter logic [3:0] CLEAR_VAL = 4'h0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scan_en,
    input  logic       clr,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [3:0] wr_addr,
    input  logic [3:0] wr_data,
    output logic [7:0] counter,
    output logic [3:0] c1,
    output logic [3:0] c2,
    output logic [3:0] c3,
    output logic [3:0] c4,
    output logic [3:0] c5,
    output logic [3:0] c6,
    output logic [3:0] c7,
    output logic [3:0] c8,
    output logic [3:0] c9,
    output logic [3:0] c10,
    output logic [3:0] c11,
    output logic [3:0] c12,
    output logic [3:0] c13,
    output logic [3:0] c14,
    output logic [3:0] c15,
    output logic [3:0] c16,
`ifdef CELL_LOCK_EN
    output logic       wr_err,
`endif
    output logic       frame_done
);
    typedef enum logic [1:0] {IDLE, SCAN, CLEAR} state_t;
    state_t     r_state, w_next;
    logic [3:0] r_cell [16];
    logic [3:0] r_cnt, r_clr_idx;
    logic [7:0] r_pre;
    logic       r_frame;
    logic       w_run, w_tc, w_acc, w_wr;
    assign wr_ready = !rst && r_state != CLEAR && !clr;
    assign w_acc    = wr_valid && wr_ready;
    assign w_run    = r_state == SCAN && scan_en && !clr;
    assign w_tc     = r_pre == 8'(SCAN_DIV - 1);
`ifdef CELL_LOCK_EN
    logic r_err;
    logic w_locked;
    assign w_locked = r_cell[wr_addr] != CLEAR_VAL;
    assign w_wr     = w_acc && !w_locked;
    assign wr_err   = r_err;
    always_ff @(posedge clk or posedge rst)
        if (rst) r_err <= 1'b0;
        else     r_err <= w_acc && w_locked;
`else
    assign w_wr = w_acc;
`endif
    always_comb begin
        w_next = r_state;
        if (r_state == CLEAR)
            w_next = r_clr_idx == 4'd15 ? (scan_en ? SCAN : IDLE) : CLEAR;
        else
            w_next = clr ? CLEAR : scan_en ? SCAN : IDLE;
    end
    // r_clr_idx wraps 15->0 on the last clear cycle, so it is already 0 for the next CLEAR
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            r_pre     <= 8'd0;
            r_clr_idx <= 4'd0;
            r_frame   <= 1'b0;
            for (int i = 0; i < 16; i++) r_cell[i] <= CLEAR_VAL;
        end else begin
            r_state <= w_next;
            r_frame <= w_run && w_tc && r_cnt == 4'd15;
            if (r_state == CLEAR) begin
                r_cell[r_clr_idx] <= CLEAR_VAL;
                r_clr_idx         <= r_clr_idx + 4'd1;
            end
            if (w_wr) r_cell[wr_addr] <= wr_data;
            if (w_run) begin
                r_pre <= w_tc ? 8'd0 : r_pre + 8'd1;
                if (w_tc) r_cnt <= r_cnt + 4'd1;
            end
        end
    end
    assign counter    = {4'd0, r_cnt};
    assign frame_done = r_frame;
    assign c1  = r_cell[0];
    assign c2  = r_cell[1];
    assign c3  = r_cell[2];
    assign c4  = r_cell[3];
    assign c5  = r_cell[4];
    assign c6  = r_cell[5];
    assign c7  = r_cell[6];
    assign c8  = r_cell[7];
    assign c9  = r_cell[8];
    assign c10 = r_cell[9];
    assign c11 = r_cell[10];
    assign c12 = r_cell[11];
    assign c13 = r_cell[12];
    assign c14 = r_cell[13];
    assign c15 = r_cell[14];
    assign c16 = r_cell[15];
endmodule

// File: tb/tb_cell_scan_ctrl.sv
// tb_cell_scan_ctrl: random and directed stimulus against a tick-count reference model of cell_scan_ctrl
module tb_cell_scan_ctrl;
    localparam int DIV = 4;
    localparam int WRAP = 16 * DIV;
`ifdef CELL_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif
    logic clk = 0, rst = 0, scan_en = 0, clr = 0, wr_valid = 0, wr_ready, frame_done, wr_err;
    logic [3:0] wr_addr = 0, wr_data = 0;
    logic [7:0] counter;
    logic [3:0] c1, c2, c3, c4, c5, c6, c7, c8, c9, c10, c11, c12, c13, c14, c15, c16;
    logic [63:0] dut_cells;
    int checks = 0, errors = 0;
    logic [3:0] m_cell [16];
    int m_t = 0, m_mode = 0, m_left = 0;
    bit m_fd, m_err;
    int fd_count;
    always #5 clk = ~clk;
    cell_scan_ctrl #(.SCAN_DIV(DIV), .CLEAR_VAL(4'h0)) dut (
        .clk(clk), .rst(rst), .scan_en(scan_en), .clr(clr), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .counter(counter),
        .c1(c1), .c2(c2), .c3(c3), .c4(c4), .c5(c5), .c6(c6), .c7(c7), .c8(c8),
        .c9(c9), .c10(c10), .c11(c11), .c12(c12), .c13(c13), .c14(c14), .c15(c15), .c16(c16),
`ifdef CELL_LOCK_EN
        .wr_err(wr_err),
`endif
        .frame_done(frame_done)
    );
`ifndef CELL_LOCK_EN
    assign wr_err = 1'b0;
`endif
    assign dut_cells = {c16, c15, c14, c13, c12, c11, c10, c9, c8, c7, c6, c5, c4, c3, c2, c1};
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic logic [63:0] m_pack();
        logic [63:0] p;
        for (int i = 0; i < 16; i++) p[i*4 +: 4] = m_cell[i];
        return p;
    endfunction
    task automatic m_reset();
        for (int i = 0; i < 16; i++) m_cell[i] = 4'h0;
        m_t = 0; m_mode = 0; m_left = 0; m_fd = 0; m_err = 0;
    endtask
    task automatic check_all();
        chk("counter", counter, 64'(m_t / DIV));
        chk("frame_done", frame_done, m_fd);
        chk("cells", dut_cells, m_pack());
        if (LOCK) chk("wr_err", wr_err, m_err);
    endtask
    // one clock: drive at negedge, check ready, model the edge, check outputs
    task automatic step(input logic se, input logic cl, input logic wv, input logic [3:0] a, input logic [3:0] d);
        bit rdy, acc;
        scan_en = se; clr = cl; wr_valid = wv; wr_addr = a; wr_data = d;
        #1;
        rdy = m_mode != 2 && !cl;
        acc = wv && rdy;
        chk("wr_ready", wr_ready, rdy);
        @(posedge clk);
        m_fd = 0; m_err = 0;
        if (m_mode == 2) begin
            m_cell[16 - m_left] = 4'h0;
            m_left--;
            if (m_left == 0) m_mode = se ? 1 : 0;
        end else if (cl) begin
            m_mode = 2; m_left = 16;
        end else begin
            if (m_mode == 1 && se) begin
                m_t = (m_t + 1) % WRAP;
                m_fd = m_t == 0;
            end
            m_mode = se ? 1 : 0;
        end
        if (acc) begin
            if (LOCK && m_cell[a] != 4'h0) m_err = 1;
            else m_cell[a] = d;
        end
        #1;
        check_all();
        if (frame_done) fd_count++;
        @(negedge clk);
    endtask
    initial begin
        int n;
        m_reset();
        rst = 1;
        #1;
        chk("rst_ready", wr_ready, 0);
        chk("rst_counter", counter, 0);
        @(negedge clk); rst = 0;
        check_all();
        fd_count = 0;
        for (int i = 0; i < 70; i++) step(1, 0, 0, 0, 0);
        chk("scan70_pulses", fd_count, 1);
        step(0, 0, 1, 4'd5, 4'h3);
        chk("write_c6", c6, 4'h3);
        n = 0;
        while (!(m_t == 9 * DIV && m_mode == 1) && n < 300) begin step(1, 0, 0, 0, 0); n++; end
        chk("pause_reach", n < 300, 1);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0);
        chk("pause_hold", counter, 9);
        n = 0;
        while (counter == 9 && n < 50) begin step(1, 0, 0, 0, 0); n++; end
        chk("resume_clks", n, DIV + 1);
        for (int i = 0; i < 16; i++) step(0, 0, 1, 4'(i), 4'hA);
        step(0, 1, 1, 4'd3, 4'h5);
        for (int i = 0; i < 16; i++) step(0, 0, 1, 4'd3, 4'h5);
        chk("clear_zero", dut_cells, m_pack());
`ifdef CELL_LOCK_EN
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 0);
        step(0, 0, 1, 4'd0, 4'h2);
        step(0, 0, 1, 4'd0, 4'h7);
        chk("lock_c1", c1, 4'h2);
        chk("lock_err", wr_err, 1);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 0);
        step(0, 0, 1, 4'd0, 4'h7);
        chk("unlock_c1", c1, 4'h7);
`endif
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 7) != 0, $urandom_range(0, 39) == 0, 1'($urandom),
                 4'($urandom), 4'($urandom));
        @(negedge clk); #2; rst = 1;
        m_reset();
        #1;
        chk("midrst_ready", wr_ready, 0);
        check_all();
        @(negedge clk); rst = 0;
        step(1, 0, 0, 0, 0);
        chk("post_rst_ready", wr_ready, 1);
        for (int i = 0; i < 200; i++)
            step($urandom_range(0, 5) != 0, $urandom_range(0, 59) == 0, 1'($urandom),
                 4'($urandom), 4'($urandom));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
